// File: rtl/jk_pkg.sv
// Shared types and JK excitation encoding for the JK bank driver.
// Excitation codes are {j,k}; the dc mask marks the bit the flop ignores for that transition.
package jk_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DRIVE  = 2'd1,
    ST_SETTLE = 2'd2
  } state_t;

  // {j,k} with don't-cares at 0, plus the mask of don't-care positions
  localparam logic [1:0] EXC_Q0_T0 = 2'b00;
  localparam logic [1:0] EXC_Q0_T1 = 2'b10;
  localparam logic [1:0] EXC_Q1_T0 = 2'b01;
  localparam logic [1:0] EXC_Q1_T1 = 2'b00;
  localparam logic [1:0] DC_K      = 2'b01;
  localparam logic [1:0] DC_J      = 2'b10;

  function automatic logic [1:0] excite_bit(input logic q, input logic t, input logic pref);
    logic [1:0] base;
    logic [1:0] dc;
    base = EXC_Q0_T0;
    dc   = DC_K;
    unique case ({q, t})
      2'b00: begin base = EXC_Q0_T0; dc = DC_K; end
      2'b01: begin base = EXC_Q0_T1; dc = DC_K; end
      2'b10: begin base = EXC_Q1_T0; dc = DC_J; end
      default: begin base = EXC_Q1_T1; dc = DC_J; end
    endcase
    return pref ? (base | dc) : base;
  endfunction

  // $clog2 floored at 1 so counters never collapse to zero width
  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/jk_excite.sv
// Combinational JK excitation encoder: per bit, (current q, target t) -> (j, k).
// pref selects how the transition's don't-care input is resolved.
module jk_excite
  import jk_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] t,
  input  logic             pref,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  always_comb begin
    j = '0;
    k = '0;
    for (int i = 0; i < WIDTH; i++) begin
      {j[i], k[i]} = excite_bit(q[i], t[i], pref);
    end
  end

endmodule

// File: rtl/jk_bank_driver.sv
// Drives a bank of JK flops toward a target word, waits for settle, checks
// read-back and retries a bounded number of times.
//
//  state     | meaning
//  ----------+-----------------------------------------------------------
//  ST_IDLE   | ready for a target; done/err pulses are visible here
//  ST_DRIVE  | j/k presented to the bank for exactly one edge
//  ST_SETTLE | j=k=0 while the bank settles; compare on the last cycle
module jk_bank_driver
  import jk_pkg::*;
#(
  parameter  int WIDTH       = 4,
  parameter  int SETTLE      = 1,
  parameter  int MAX_RETRY   = 2,
  parameter  int TOGGLE_PREF = 0,
  localparam int RW          = clog2_min1(MAX_RETRY + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             tgt_valid,
  output logic             tgt_ready,
  input  logic [WIDTH-1:0] tgt_data,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k,
  input  logic [WIDTH-1:0] q_fb,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [RW-1:0]    retries
);

  localparam int            CW        = clog2_min1(SETTLE);
  localparam logic [CW-1:0] CNT_INIT  = CW'(SETTLE - 1);
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic          PREF      = (TOGGLE_PREF != 0);

  state_t           state;
  state_t           state_nxt;
  logic [WIDTH-1:0] tgt_q;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] exc_t;
  logic [WIDTH-1:0] exc_j;
  logic [WIDTH-1:0] exc_k;
  logic             accept;
  logic             settle_end;
  logic             match;
  logic             can_retry;

  // One encoder serves both the accept (fresh data) and retry (held target) paths
  assign exc_t      = (state == ST_IDLE) ? tgt_data : tgt_q;
  assign accept     = tgt_valid && (state == ST_IDLE);
  assign settle_end = (state == ST_SETTLE) && (cnt == '0);
  assign match      = (q_fb == tgt_q);
  assign can_retry  = (retries < RETRY_MAX);

  jk_excite #(
    .WIDTH (WIDTH)
  ) u_excite (
    .q    (q_fb),
    .t    (exc_t),
    .pref (PREF),
    .j    (exc_j),
    .k    (exc_k)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: begin
        if (accept) state_nxt = ST_DRIVE;
      end
      ST_DRIVE: begin
        state_nxt = ST_SETTLE;
      end
      ST_SETTLE: begin
        if (settle_end) begin
          if (!match && can_retry) state_nxt = ST_DRIVE;
          else                     state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    tgt_ready = (state == ST_IDLE);
    busy      = (state == ST_DRIVE) || (state == ST_SETTLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j       <= '0;
      k       <= '0;
      done    <= 1'b0;
      err     <= 1'b0;
      retries <= '0;
      tgt_q   <= '0;
      cnt     <= '0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      unique case (state)
        ST_IDLE: begin
          if (accept) begin
            tgt_q   <= tgt_data;
            j       <= exc_j;
            k       <= exc_k;
            retries <= '0;
          end
        end
        ST_DRIVE: begin
          // bank samples the drive on this edge; hold from here on
          j   <= '0;
          k   <= '0;
          cnt <= CNT_INIT;
        end
        ST_SETTLE: begin
          if (cnt == '0) begin
            if (match) begin
              done <= 1'b1;
            end else if (can_retry) begin
              retries <= retries + 1'b1;
              j       <= exc_j;
              k       <= exc_k;
            end else begin
              err <= 1'b1;
            end
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        default: begin
          j <= '0;
          k <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_jk_bank_driver.sv
// Bench: two driver instances (set/reset-only and toggle-preferring), each
// steering its own behavioural 4-bit JK bank.
module tb_jk_bank_driver;

  logic       clk;
  logic       rst_n;
  logic       bank_clr;
  logic       tgt_valid [2];
  logic       tgt_ready [2];
  logic [3:0] tgt_data  [2];
  logic [3:0] j         [2];
  logic [3:0] k         [2];
  logic [3:0] q_fb      [2];
  logic       busy      [2];
  logic       done      [2];
  logic       err       [2];
  logic [1:0] retries   [2];
  logic [3:0] qb        [2];
  logic [3:0] fmask     [2];

  int checks = 0;
  int errors = 0;
  int jk_bad = 0;
  int both_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  jk_bank_driver #(.WIDTH(4), .SETTLE(1), .MAX_RETRY(2), .TOGGLE_PREF(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[0]), .tgt_ready(tgt_ready[0]),
    .tgt_data(tgt_data[0]), .j(j[0]), .k(k[0]), .q_fb(q_fb[0]), .busy(busy[0]),
    .done(done[0]), .err(err[0]), .retries(retries[0]));

  jk_bank_driver #(.WIDTH(4), .SETTLE(3), .MAX_RETRY(3), .TOGGLE_PREF(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .tgt_valid(tgt_valid[1]), .tgt_ready(tgt_ready[1]),
    .tgt_data(tgt_data[1]), .j(j[1]), .k(k[1]), .q_fb(q_fb[1]), .busy(busy[1]),
    .done(done[1]), .err(err[1]), .retries(retries[1]));

  // JK flop banks (not reset by rst_n; cleared once by the bench)
  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      if (bank_clr) qb[i] <= 4'b0000;
      else          qb[i] <= (j[i] & ~qb[i]) | (~k[i] & qb[i]);
    end
  end

  assign q_fb[0] = qb[0] & ~fmask[0];
  assign q_fb[1] = qb[1] & ~fmask[1];

  always @(negedge clk) begin
    if (rst_n && ((j[0] & k[0]) != 4'b0000)) jk_bad++;
    for (int i = 0; i < 2; i++) if (done[i] && err[i]) both_bad++;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: iterate attempts, applying the excitation table and JK equation
  function automatic void model_op(input int d, input logic [3:0] q0, input logic [3:0] t,
                                   input logic [3:0] m, output logic [3:0] j0,
                                   output logic [3:0] k0, output logic [3:0] qe,
                                   output bit e, output int r, output int lat);
    logic [3:0] q, jj, kk, obs;
    int st, mr;
    bit pref, fin;
    st = (d == 0) ? 1 : 3;
    mr = (d == 0) ? 2 : 3;
    pref = (d == 1);
    q = q0; e = 1; r = mr; lat = (mr + 1) * (st + 1); j0 = '0; k0 = '0; fin = 0;
    for (int a = 0; a <= mr; a++) begin
      if (!fin) begin
        obs = q & ~m;
        for (int b = 0; b < 4; b++) begin
          jj[b] = obs[b] ? pref : t[b];
          kk[b] = obs[b] ? ~t[b] : pref;
        end
        if (a == 0) begin j0 = jj; k0 = kk; end
        q = (jj & ~q) | (~kk & q);
        if ((q & ~m) == t) begin
          e = 0; r = a; lat = (a + 1) * (st + 1); fin = 1;
        end
      end
    end
    qe = q;
  endfunction

  task automatic run_op(input int d, input logic [3:0] tgt, input logic [3:0] m, input bit intr,
                        output logic [3:0] j0, output logic [3:0] k0, output logic [3:0] qe,
                        output bit e, output int r, output int lat, output bit pulse_ok);
    @(posedge clk); #1;
    chk("ready_idle", int'(tgt_ready[d]), 1);
    fmask[d] = m;
    tgt_valid[d] = 1'b1;
    tgt_data[d] = tgt;
    @(posedge clk); #1;
    tgt_valid[d] = 1'b0;
    tgt_data[d] = ~tgt;
    j0 = j[d]; k0 = k[d];
    lat = -1; e = 0; r = -1; qe = 4'bxxxx; pulse_ok = 0;
    for (int n = 1; n <= 40 && lat < 0; n++) begin
      @(posedge clk); #1;
      if (intr && n == 1) begin
        chk("ready_low_busy", int'(tgt_ready[d]), 0);
        tgt_valid[d] = 1'b1;
        tgt_data[d] = 4'b1111;
      end
      if (intr && n == 2) tgt_valid[d] = 1'b0;
      if (done[d] || err[d]) begin
        lat = n; e = err[d]; r = int'(retries[d]); qe = qb[d];
      end
    end
    if (lat > 0) begin
      @(posedge clk); #1;
      pulse_ok = !done[d] && !err[d];
    end
    fmask[d] = 4'b0000;
  endtask

  typedef struct {
    int d; logic [3:0] tgt; logic [3:0] m; bit intr;
    logic [3:0] ej; logic [3:0] ek; logic [3:0] eq; bit ee; int er; int el;
  } vec_t;

  vec_t tv [11];

  initial begin
    logic [3:0] j0, k0, qe, mj, mk, mq, tgt, m;
    bit e, me, pok;
    int r, lat, mr, ml, d, n;

    tv[0]  = '{0, 4'b1010, 4'b0000, 0, 4'b1010, 4'b0000, 4'b1010, 0, 0, 2};
    tv[1]  = '{1, 4'b1010, 4'b0000, 0, 4'b1010, 4'b1111, 4'b1010, 0, 0, 4};
    tv[2]  = '{1, 4'b0110, 4'b0000, 0, 4'b1110, 4'b1101, 4'b0110, 0, 0, 4};
    tv[3]  = '{0, 4'b0001, 4'b0001, 0, 4'b0001, 4'b1010, 4'b0001, 1, 2, 6};
    tv[4]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0001, 4'b0000, 0, 0, 2};
    tv[5]  = '{0, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 4'b0000, 0, 0, 2};
    tv[6]  = '{1, 4'b0110, 4'b0000, 0, 4'b0110, 4'b1001, 4'b0110, 0, 0, 4};
    tv[7]  = '{1, 4'b1001, 4'b1000, 0, 4'b1111, 4'b1111, 4'b0001, 1, 3, 16};
    tv[8]  = '{0, 4'b1111, 4'b0000, 0, 4'b1111, 4'b0000, 4'b1111, 0, 0, 2};
    tv[9]  = '{1, 4'b0001, 4'b0000, 0, 4'b0001, 4'b1110, 4'b0001, 0, 0, 4};
    tv[10] = '{1, 4'b1010, 4'b0000, 1, 4'b1011, 4'b1111, 4'b1010, 0, 0, 4};

    rst_n = 1'b0;
    bank_clr = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tgt_valid[i] = 1'b0; tgt_data[i] = 4'b0000; fmask[i] = 4'b0000;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk("rst_j", int'(j[i]), 0);
      chk("rst_k", int'(k[i]), 0);
      chk("rst_ready", int'(tgt_ready[i]), 1);
      chk("rst_busy_done_err", int'({busy[i], done[i], err[i]}), 0);
      chk("rst_retries", int'(retries[i]), 0);
    end
    rst_n = 1'b1;
    bank_clr = 1'b0;

    // reset while in DRIVE
    @(posedge clk); #1;
    tgt_valid[0] = 1'b1; tgt_data[0] = 4'b0101;
    @(posedge clk); #1;
    tgt_valid[0] = 1'b0;
    chk("mid_busy", int'(busy[0]), 1);
    chk("mid_j", int'(j[0]), 4'b0101);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_jk", int'({j[0], k[0]}), 0);
    chk("mid_rst_ready", int'(tgt_ready[0]), 1);
    chk("mid_rst_flags", int'({busy[0], done[0], err[0]}), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    n = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done[0] || err[0]) n++;
    end
    chk("mid_rst_no_pulse", n, 0);
    chk("mid_rst_bank", int'(qb[0]), 0);

    foreach (tv[i]) begin
      run_op(tv[i].d, tv[i].tgt, tv[i].m, tv[i].intr, j0, k0, qe, e, r, lat, pok);
      chk($sformatf("v%0d_j", i), int'(j0), int'(tv[i].ej));
      chk($sformatf("v%0d_k", i), int'(k0), int'(tv[i].ek));
      chk($sformatf("v%0d_q", i), int'(qe), int'(tv[i].eq));
      chk($sformatf("v%0d_err", i), int'(e), int'(tv[i].ee));
      chk($sformatf("v%0d_retries", i), r, tv[i].er);
      chk($sformatf("v%0d_latency", i), lat, tv[i].el);
      chk($sformatf("v%0d_pulse1", i), int'(pok), 1);
    end

    // back-to-back with tgt_valid held; dut0 bank is 1111 here
    @(posedge clk); #1;
    tgt_valid[0] = 1'b1; tgt_data[0] = 4'b0011;
    @(posedge clk); #1;
    tgt_data[0] = 4'b1100;
    chk("b2b_j1", int'(j[0]), 4'b0000);
    chk("b2b_k1", int'(k[0]), 4'b1100);
    n = -1;
    for (int c = 1; c <= 10 && n < 0; c++) begin
      @(posedge clk); #1;
      if (done[0]) n = c;
    end
    chk("b2b_lat1", n, 2);
    chk("b2b_ready_in_done", int'(tgt_ready[0]), 1);
    chk("b2b_q1", int'(qb[0]), 4'b0011);
    @(posedge clk); #1;
    tgt_valid[0] = 1'b0;
    chk("b2b_accept2", int'({busy[0], done[0]}), 2'b10);
    chk("b2b_j2", int'(j[0]), 4'b1100);
    chk("b2b_k2", int'(k[0]), 4'b0011);
    n = -1;
    for (int c = 1; c <= 10 && n < 0; c++) begin
      @(posedge clk); #1;
      if (done[0]) n = c;
    end
    chk("b2b_lat2", n, 2);
    chk("b2b_q2", int'(qb[0]), 4'b1100);

    // randomized ops against the reference model
    for (int i = 0; i < 40; i++) begin
      d = $urandom_range(0, 1);
      tgt = 4'($urandom_range(0, 15));
      m = ($urandom_range(0, 3) == 0) ? 4'($urandom_range(0, 15)) : 4'b0000;
      model_op(d, qb[d], tgt, m, mj, mk, mq, me, mr, ml);
      run_op(d, tgt, m, 0, j0, k0, qe, e, r, lat, pok);
      chk($sformatf("r%0d_j", i), int'(j0), int'(mj));
      chk($sformatf("r%0d_k", i), int'(k0), int'(mk));
      chk($sformatf("r%0d_q", i), int'(qe), int'(mq));
      chk($sformatf("r%0d_err", i), int'(e), int'(me));
      chk($sformatf("r%0d_retries", i), r, mr);
      chk($sformatf("r%0d_latency", i), lat, ml);
      chk($sformatf("r%0d_pulse1", i), int'(pok), 1);
    end

    chk("pref0_no_jk11", jk_bad, 0);
    chk("done_err_overlap", both_bad, 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
